// File: rtl/btn_pkg.sv
// Shared constants and types for the front-panel button debouncer.
package btn_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 250_000;
    localparam int DEFAULT_REPEAT_DELAY  = 25_000_000;
    localparam int DEFAULT_REPEAT_PERIOD = 5_000_000;

    // Reference clock used to turn millisecond figures into cycle counts.
    localparam int CLK_HZ        = 50_000_000;
    localparam int CYCLES_PER_MS = CLK_HZ / 1000;

    typedef enum logic {
        PH_DELAY  = 1'b0,
        PH_PERIOD = 1'b1
    } rep_phase_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, stability qualifier, press/release
// strobes and optional hold-to-repeat generator.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt,
    output logic press_next
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic IDLE = (ACTIVE_LOW != 0);

    logic          sync1;
    logic          sync2;
    logic          s;
    logic          accept;
    logic [SW-1:0] stab_cnt;

    // Synchroniser resets to the idle raw level so the normalised sample is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign s = sync2 ^ IDLE;

    always_comb begin
        accept     = (s != level) && (stab_cnt == STAB_LAST);
        press_next = accept & s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level    <= 1'b0;
            stab_cnt <= '0;
            press    <= 1'b0;
            rel      <= 1'b0;
        end else begin
            press <= accept & s;
            rel   <= accept & ~s;
            if (s == level) begin
                stab_cnt <= '0;
            end else if (accept) begin
                level    <= s;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    if (REPEAT_EN != 0) begin : g_rep
        localparam int HMAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
        localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
        localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DELAY - 1);
        localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);

        rep_phase_t    phase;
        rep_phase_t    phase_n;
        logic [HW-1:0] hold_cnt;
        logic [HW-1:0] hold_cnt_n;
        logic          rpt_n;

        always_ff @(posedge clk) begin
            if (rst) begin
                phase    <= PH_DELAY;
                hold_cnt <= '0;
                rpt      <= 1'b0;
            end else begin
                phase    <= phase_n;
                hold_cnt <= hold_cnt_n;
                rpt      <= rpt_n;
            end
        end

        // Any accepted edge restarts the hold timer, which also keeps a
        // repeat from landing on a press or release cycle.
        always_comb begin
            phase_n    = phase;
            hold_cnt_n = hold_cnt + 1'b1;
            rpt_n      = 1'b0;
            if (accept || !level) begin
                phase_n    = PH_DELAY;
                hold_cnt_n = '0;
            end else if (phase == PH_DELAY) begin
                if (hold_cnt == DLY_LAST) begin
                    rpt_n      = 1'b1;
                    phase_n    = PH_PERIOD;
                    hold_cnt_n = '0;
                end
            end else if (hold_cnt == PER_LAST) begin
                rpt_n      = 1'b1;
                hold_cnt_n = '0;
            end
        end
    end else begin : g_norep
        assign rpt = 1'b0;
    end

endmodule

// File: rtl/btn_debouncer_multi.sv
// N-channel front-panel debouncer with press/release/repeat strobes and a
// combined any_press flag.
module btn_debouncer_multi
    import btn_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             any_press
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("REPEAT_DELAY must be at least 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("REPEAT_PERIOD must be at least 1");
    end

    logic [N_BTN-1:0] press_next;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .ACTIVE_LOW    (ACTIVE_LOW),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .raw        (btn_raw[i]),
            .level      (btn_level[i]),
            .press      (btn_press[i]),
            .rel        (btn_release[i]),
            .rpt        (btn_repeat[i]),
            .press_next (press_next[i])
        );
    end

    // Registered from the pre-edge press terms so it lines up with btn_press.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_next;
        end
    end

endmodule

// File: tb/tb_btn_debouncer_multi.sv
// Bench for btn_debouncer_multi: active-high and active-low instances share
// one run-length/timestamp reference model plus literal timing pins.
module tb_btn_debouncer_multi;

    localparam int NB = 4;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] raw;
    logic [NB-1:0] raw_inv;
    logic [NB-1:0] lvl0, prs0, rel0, rep0;
    logic [NB-1:0] lvl1, prs1, rel1, rep1;
    logic          any0, any1;

    int n_vec  = 0;
    int n_fail = 0;
    bit seen_rst = 1'b0;

    logic [NB-1:0] hist[$];
    int            run[NB];
    logic          runval[NB];
    logic          m_lvl[NB];
    int            tp[NB];
    int            t = 0;
    logic [NB-1:0] e_lvl, e_prs, e_rel, e_rep;
    logic          e_any;

    always #5 clk = ~clk;
    assign raw_inv = ~raw;

    btn_debouncer_multi #(
        .N_BTN         (NB),
        .STABLE_CYCLES (SC),
        .ACTIVE_LOW    (0),
        .REPEAT_EN     (1),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut0 (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (raw),
        .btn_level   (lvl0),
        .btn_press   (prs0),
        .btn_release (rel0),
        .btn_repeat  (rep0),
        .any_press   (any0)
    );

    btn_debouncer_multi #(
        .N_BTN         (NB),
        .STABLE_CYCLES (SC),
        .ACTIVE_LOW    (1),
        .REPEAT_EN     (1),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (raw_inv),
        .btn_level   (lvl1),
        .btn_press   (prs1),
        .btn_release (rel1),
        .btn_repeat  (rep1),
        .any_press   (any1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Reference: a level is accepted once the sample two edges old has held
    // one value for SC consecutive edges; repeats fall at fixed offsets from
    // the press timestamp while still held.
    always @(posedge clk) begin : model_cmp
        logic [NB-1:0] r;
        logic [NB-1:0] s;
        logic [NB-1:0] dummy;
        logic          x;
        logic          acc;
        r = raw;
        x = rst;
        if (x === 1'b1) begin
            hist.delete();
            hist.push_back('0);
            hist.push_back('0);
            for (int c = 0; c < NB; c++) begin
                run[c]    = 0;
                runval[c] = 1'b0;
                m_lvl[c]  = 1'b0;
                tp[c]     = 0;
            end
            e_lvl = '0; e_prs = '0; e_rel = '0; e_rep = '0; e_any = 1'b0;
            seen_rst = 1'b1;
        end else if (seen_rst) begin
            s = hist[1];
            hist.push_front(r);
            dummy = hist.pop_back();
            t++;
            e_prs = '0; e_rel = '0; e_rep = '0;
            for (int c = 0; c < NB; c++) begin
                if (s[c] == runval[c]) begin
                    run[c]++;
                end else begin
                    runval[c] = s[c];
                    run[c]    = 1;
                end
                acc = (s[c] != m_lvl[c]) && (run[c] >= SC);
                if (acc) begin
                    m_lvl[c] = s[c];
                    e_prs[c] = s[c];
                    e_rel[c] = !s[c];
                    if (s[c]) tp[c] = t;
                end else if (m_lvl[c] && (t - tp[c]) >= RD && ((t - tp[c] - RD) % RP) == 0) begin
                    e_rep[c] = 1'b1;
                end
                e_lvl[c] = m_lvl[c];
            end
            e_any = |e_prs;
        end
        #1;
        if (seen_rst) begin
            chk("model_dut0", {lvl0, prs0, rel0, rep0, any0}, {e_lvl, e_prs, e_rel, e_rep, e_any});
            chk("model_dut1", {lvl1, prs1, rel1, rep1, any1}, {e_lvl, e_prs, e_rel, e_rep, e_any});
        end
    end

    initial begin
        int np, nr, ns;
        int hold[NB];
        rst = 1'b1;
        raw = '0;
        repeat (3) cyc();
        chk("reset_dut0", {lvl0, prs0, rel0, rep0, any0}, 0);
        chk("reset_dut1", {lvl1, prs1, rel1, rep1, any1}, 0);
        rst = 1'b0;

        // Clean press on channel 0
        raw[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("s1_press_dut0", prs0[0], (k == 6));
            chk("s1_press_dut1", prs1[0], (k == 6));
            if (k == 6) begin
                chk("s1_any", any0, 1);
                chk("s1_level", lvl0[0], 1);
            end
        end

        // Glitch of 3 cycles on channel 1, then a 4-cycle pulse that qualifies
        raw[1] = 1'b1;
        repeat (3) cyc();
        raw[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("s2_glitch", {lvl0[1], prs0[1], rel0[1]}, 0);
        end
        np = 0; nr = 0;
        raw[1] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) raw[1] = 1'b0;
            cyc();
            np += int'(prs0[1]);
            nr += int'(rel0[1]);
        end
        chk("s2_press_count", np, 1);
        chk("s2_release_count", nr, 1);

        // Auto-repeat on channel 2
        raw[2] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("s3_press", prs0[2], (k == 6));
        end
        for (int k = 1; k <= 40; k++) begin
            cyc();
            chk("s3_repeat", rep0[2], (k inside {10, 13, 16, 19, 22, 25, 28, 31, 34, 37, 40}));
        end
        raw[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("s3_release", rel0[2], (k == 6));
            chk("s3_repeat_tail", rep0[2], (k == 3));
        end

        // Simultaneous press on channels 0 and 3, then reset mid-repeat
        raw = '0;
        repeat (12) cyc();
        raw[0] = 1'b1;
        raw[3] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("s5_press_dut0", prs0, (k == 6) ? 4'b1001 : 4'b0000);
            chk("s5_press_dut1", prs1, (k == 6) ? 4'b1001 : 4'b0000);
            if (k == 6) begin
                chk("s5_any_dut0", any0, 1);
                chk("s5_any_dut1", any1, 1);
            end
        end
        repeat (14) cyc();
        rst = 1'b1;
        cyc();
        chk("s5_rst_dut0", {lvl0, prs0, rel0, rep0, any0}, 0);
        chk("s5_rst_dut1", {lvl1, prs1, rel1, rep1, any1}, 0);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("s5_repress_dut0", prs0, (k == 6) ? 4'b1001 : 4'b0000);
            chk("s5_repress_dut1", prs1, (k == 6) ? 4'b1001 : 4'b0000);
        end

        // Bounce train on channel 0, ending high
        raw = '0;
        repeat (12) cyc();
        ns = 0;
        for (int i = 0; i < 50; i++) begin
            raw[0] = (((i / 2) % 2) == 0);
            cyc();
            ns += int'(prs0[0]) + int'(rel0[0]) + int'(rep0[0]);
        end
        chk("s6_quiet", ns, 0);
        chk("s6_level", lvl0[0], 0);
        for (int k = 3; k <= 8; k++) begin
            cyc();
            chk("s6_press", prs0[0], (k == 6));
        end

        // Randomised hold lengths with occasional reset
        for (int c = 0; c < NB; c++) hold[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold[c] == 0) begin
                    raw[c] = ~raw[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 40))
                                                          : int'($urandom_range(1, 5));
                end else begin
                    hold[c]--;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
